dma_stream_reader: RTL and testbench

- Master-stream read engine that sits directly upstream of bram_top's Port A read path.
- Drives dma_rd_en and dma_read_pointer for a programmed word count, and tracks the fixed read latency.
- Captures dma_rd_data into a small credit-managed FIFO, then presents the data as an AXI-Stream master with tlast on the final word.
- Absorbs tready backpressure without losing in-flight reads.

---
 rtl/dma_pkg.sv | 15 +
 rtl/dma_stream_fifo.sv | 70 +++++++
 rtl/dma_stream_reader.sv | 126 ++++++++++++
 tb/tb_dma_stream_reader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and default sizing for the DMA stream reader slice.
// Imported by the reader top and its output FIFO.
package dma_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rd_state_t;

   localparam int RD_LATENCY_DEF = 2;
   localparam int FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/dma_stream_fifo.sv
// First-word-fall-through synchronous FIFO for the read-data stream.
// Depth must be a power of two so the pointers wrap naturally.
module stream_fifo
   import dma_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = FIFO_DEPTH_DEF,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [DW-1:0] din_i,
   output logic [DW-1:0] dout_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rd_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && !full_o;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

   // Credit accounting upstream must make this unreachable.
   always_ff @(posedge clk) begin
      if (!rst) assert (!(push_i && full_o));
   end

endmodule

// File: rtl/dma_stream_reader.sv
// Credit-managed BRAM read engine feeding an AXI-Stream master port.
// Reads are issued only when a FIFO slot is guaranteed for their data.
module dma_stream_reader
   import dma_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int PTR_WIDTH  = 16,
   parameter int RD_LATENCY = RD_LATENCY_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [PTR_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic                  dma_rd_en,
   output logic [PTR_WIDTH-1:0]  dma_read_pointer,
   input  logic [DATA_WIDTH-1:0] dma_rd_data,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   rd_state_t             state_q, state_d;
   logic [PTR_WIDTH-1:0]  len_q, len_d;
   logic [PTR_WIDTH-1:0]  iss_q, iss_d;
   logic [PTR_WIDTH-1:0]  beat_q, beat_d;
   logic [PTR_WIDTH-1:0]  len_m1;
   logic [RD_LATENCY-1:0] pipe_q, pipe_d;
   logic [CW-1:0]         fifo_cnt;
   logic                  fifo_full, fifo_empty;
   logic                  issue, push, pop;
   logic [31:0]           inflight;

   assign len_m1 = len_q - PTR_WIDTH'(1);
   assign push   = pipe_q[RD_LATENCY-1];
   assign pop    = m_axis_tvalid && m_axis_tready;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++)
         inflight = inflight + 32'(pipe_q[i]);
   end

   // Every outstanding read already owns a FIFO slot.
   assign issue = (state_q == RUN) && !fifo_full &&
                  ((inflight + 32'(fifo_cnt)) < 32'(FIFO_DEPTH));

   always_comb begin
      pipe_d[0] = issue;
      for (int i = 1; i < RD_LATENCY; i++)
         pipe_d[i] = pipe_q[i-1];
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      iss_d   = iss_q;
      beat_d  = beat_q;
      if (pop) beat_d = beat_q + PTR_WIDTH'(1);
      unique case (state_q)
         IDLE: begin
            if (start) begin
               len_d   = length;
               iss_d   = '0;
               beat_d  = '0;
               state_d = (length == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (issue) begin
               iss_d = iss_q + PTR_WIDTH'(1);
               if (iss_q == len_m1) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && m_axis_tlast) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         iss_q   <= '0;
         beat_q  <= '0;
         pipe_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         iss_q   <= iss_d;
         beat_q  <= beat_d;
         pipe_q  <= pipe_d;
      end
   end

   stream_fifo #(
      .DW    (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (dma_rd_data),
      .dout_o  (m_axis_tdata),
      .count_o (fifo_cnt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign busy             = (state_q != IDLE);
   assign done             = (state_q == DONE);
   assign dma_rd_en        = issue;
   assign dma_read_pointer = iss_q;
   assign m_axis_tvalid    = !fifo_empty;
   assign m_axis_tlast     = m_axis_tvalid && (beat_q == len_m1);

endmodule

// File: tb/tb_dma_stream_reader.sv
// Directed bench for dma_stream_reader with a two-cycle BRAM read model.
// Expected beats, pointers and cycle offsets are hand-derived constants.
module tb_dma_stream_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] length = '0;
   logic        busy, done, dma_rd_en;
   logic [15:0] dma_read_pointer;
   logic [31:0] dma_rd_data;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int t0     = 0;

   dma_stream_reader dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .length           (length),
      .busy             (busy),
      .done             (done),
      .dma_rd_en        (dma_rd_en),
      .dma_read_pointer (dma_read_pointer),
      .dma_rd_data      (dma_rd_data),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tready    (m_axis_tready),
      .m_axis_tlast     (m_axis_tlast)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // BRAM: address register, then data register.
   logic [15:0] addr_q = '0;
   logic [31:0] data_q = '0;
   always @(posedge clk) begin
      addr_q <= dma_read_pointer;
      data_q <= 32'h100 + {16'h0, addr_q};
   end
   assign dma_rd_data = data_q;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int   rd_ptr_q[$];
   int   rd_cyc_q[$];
   int   bt_dat_q[$];
   int   bt_cyc_q[$];
   int   bt_lst_q[$];
   int   issued, popped, done_cnt, done_cyc, stalls;
   bit   prev_stall;
   logic [31:0] prev_data;
   logic prev_last;

   always @(negedge clk) begin
      if (rst || (start && !busy)) begin
         rd_ptr_q.delete();
         rd_cyc_q.delete();
         bt_dat_q.delete();
         bt_cyc_q.delete();
         bt_lst_q.delete();
         issued = 0; popped = 0; done_cnt = 0;
         done_cyc = -1; stalls = 0; prev_stall = 0;
      end else begin
         if (busy) begin
            check("credit", 32'((issued - popped + int'(dma_rd_en)) <= 4), 1);
            if (issued - popped == 4) begin
               stalls++;
               check("rd_stall", 32'(dma_rd_en), 0);
            end
         end
         if (prev_stall) begin
            check("hold_valid", 32'(m_axis_tvalid), 1);
            check("hold_data", m_axis_tdata, prev_data);
            check("hold_last", 32'(m_axis_tlast), 32'(prev_last));
         end
         if (dma_rd_en) begin
            rd_ptr_q.push_back(int'(dma_read_pointer));
            rd_cyc_q.push_back(cyc - t0);
            issued++;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            bt_dat_q.push_back(int'(m_axis_tdata));
            bt_cyc_q.push_back(cyc - t0);
            bt_lst_q.push_back(int'(m_axis_tlast));
            popped++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc - t0;
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_last  = m_axis_tlast;
      end
   end

   task automatic kick(input logic [15:0] len);
      @(posedge clk); #1;
      start  = 1'b1;
      length = len;
      t0     = cyc;
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   task automatic wait_done(input int mode, input int budget);
      bit seen = 0;
      int k;
      for (int n = 0; n < budget && !seen; n++) begin
         @(posedge clk); #1;
         k = cyc - t0;
         case (mode)
            1:       m_axis_tready = (k % 4 == 0) || (k % 4 == 3);
            2:       m_axis_tready = (k >= 6);
            default: ;
         endcase
         @(negedge clk);
         if (done_cnt > 0) seen = 1;
      end
      check("done_seen", 32'(seen), 1);
   endtask

   task automatic check_xfer(input int n);
      check("n_reads", rd_ptr_q.size(), n);
      check("n_beats", bt_dat_q.size(), n);
      check("n_done", done_cnt, 1);
      for (int i = 0; i < n; i++) begin
         if (i < rd_ptr_q.size())
            check("rd_ptr", rd_ptr_q[i], i);
         if (i < bt_dat_q.size()) begin
            check("beat_data", bt_dat_q[i], 32'h100 + i);
            check("beat_last", bt_lst_q[i], 32'(i == n - 1));
         end
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_rd_en", 32'(dma_rd_en), 0);
      check("rst_ptr", 32'(dma_read_pointer), 0);
      check("rst_tvalid", 32'(m_axis_tvalid), 0);
      check("rst_tlast", 32'(m_axis_tlast), 0);

      // length 4, full throughput
      m_axis_tready = 1'b1;
      kick(16'd4);
      wait_done(0, 50);
      check_xfer(4);
      for (int i = 0; i < 4; i++) begin
         if (i < rd_cyc_q.size()) check("rd_cyc", rd_cyc_q[i], i + 1);
         if (i < bt_cyc_q.size()) check("beat_cyc", bt_cyc_q[i], i + 4);
      end
      check("done_cyc4", done_cyc, 8);

      // length 8, backpressure 1,0,0,1
      kick(16'd8);
      wait_done(1, 200);
      check_xfer(8);
      check("stall_seen", 32'(stalls > 0), 1);
      m_axis_tready = 1'b1;

      // length 0
      kick(16'd0);
      #1;
      check("z_busy", 32'(busy), 1);
      check("z_done", 32'(done), 1);
      check("z_tvalid", 32'(m_axis_tvalid), 0);
      check("z_rd_en", 32'(dma_rd_en), 0);
      @(posedge clk); #2;
      check("z_busy2", 32'(busy), 0);
      check("z_done2", 32'(done), 0);
      check("z_reads", rd_ptr_q.size(), 0);
      check("z_beats", bt_dat_q.size(), 0);
      check("z_ndone", done_cnt, 1);

      // length 6 with a stray start during RUN
      kick(16'd6);
      repeat (2) @(posedge clk);
      #1 start = 1'b1; length = 16'd3;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(0, 100);
      check_xfer(6);

      // reset mid-transfer of length 10
      kick(16'd10);
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("ab_busy", 32'(busy), 0);
      check("ab_done", 32'(done), 0);
      check("ab_rd_en", 32'(dma_rd_en), 0);
      check("ab_ptr", 32'(dma_read_pointer), 0);
      check("ab_tvalid", 32'(m_axis_tvalid), 0);
      check("ab_tlast", 32'(m_axis_tlast), 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         check("ab_late", 32'(m_axis_tvalid), 0);
      end
      check("ab_no_done", done_cnt, 0);
      kick(16'd2);
      wait_done(0, 50);
      check_xfer(2);

      // length 1 held under backpressure
      m_axis_tready = 1'b0;
      kick(16'd1);
      repeat (3) @(posedge clk);
      #2;
      check("h_tvalid", 32'(m_axis_tvalid), 1);
      check("h_tlast", 32'(m_axis_tlast), 1);
      check("h_tdata", m_axis_tdata, 32'h100);
      wait_done(2, 50);
      check_xfer(1);
      if (bt_cyc_q.size() > 0) check("h_beat_cyc", bt_cyc_q[0], 6);
      check("h_done_cyc", done_cyc, 7);
      m_axis_tready = 1'b1;

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
